silife_max7219_scan: RTL and testbench

// - Downstream consumer of the cell matrix: walks rows via row_select/cells (the same row

---
 rtl/silife_max7219_scan_if.sv | 29 ++
 rtl/silife_max7219_scan.sv | 200 ++++++++++++++++++++
 tb/tb_silife_max7219_scan.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/silife_max7219_scan_if.sv
// Row-fetch, SPI and control signals between the MAX7219 scanner (master) and its
// surroundings: cell matrix, LED driver and frame controller (slave).
interface silife_max7219_scan_if #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic             start;
    logic             init;
    logic [3:0]       intensity;
    logic [ROW_W-1:0] row_select;
    logic [WIDTH-1:0] cells;
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_cs_n;
    logic             busy;
    logic             frame_done;

    modport master (
        input  start, init, intensity, cells,
        output row_select, spi_sck, spi_mosi, spi_cs_n, busy, frame_done
    );

    modport slave (
        output start, init, intensity, cells,
        input  row_select, spi_sck, spi_mosi, spi_cs_n, busy, frame_done
    );
endinterface

// File: rtl/silife_max7219_scan.sv
// Scans the cell matrix row by row and streams each row as a 16-bit packet to a
// MAX7219-style LED driver, optionally preceded by the five-packet register init sequence.
module silife_max7219_scan #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    silife_max7219_scan_if.master    bus
);
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t           state_r;
    logic             load_ph_r;
    logic             init_active_r;
    logic             init_pending_r;
    logic [2:0]       idx_r;
    logic [ROW_W-1:0] row_r;
    logic [DIV_W-1:0] div_r;
    logic [3:0]       bit_r;
    logic             tail_r;
    logic [15:0]      shreg_r;
    logic             sck_r;
    logic             mosi_r;
    logic             cs_n_r;
    logic             busy_r;
    logic             done_r;

    logic             div_wrap_s;
    logic             launch_s;
    logic [15:0]      pkt_s;

    // Init sequence: test off, no decode, intensity, scan limit, normal operation.
    function automatic logic [15:0] init_packet(input logic [2:0] idx, input logic [3:0] inten);
        logic [15:0] pkt;
        case (idx)
            3'd0:    pkt = 16'h0F00;
            3'd1:    pkt = 16'h0900;
            3'd2:    pkt = {8'h0A, 4'h0, inten};
            3'd3:    pkt = {8'h0B, 8'(HEIGHT - 1)};
            3'd4:    pkt = 16'h0C01;
            default: pkt = 16'h0C01;
        endcase
        return pkt;
    endfunction

    assign div_wrap_s = (div_r == DIV_LAST);

    // Decide when a new packet starts shifting this cycle.
    always_comb begin
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE:  launch_s = bus.start && (init_pending_r || bus.init);
            ST_LOAD:  launch_s = load_ph_r;
            ST_GAP:   launch_s = div_wrap_s && init_active_r && (idx_r != 3'd4);
            default:  launch_s = 1'b0;
        endcase
    end

    // Packet to load on launch; cells only matter in the second LOAD cycle.
    always_comb begin
        pkt_s = 16'h0000;
        case (state_r)
            ST_IDLE:  pkt_s = init_packet(3'd0, bus.intensity);
            ST_LOAD:  pkt_s = {4'h0, 4'(row_r) + 4'd1, bus.cells};
            ST_GAP:   pkt_s = init_packet(idx_r + 3'd1, bus.intensity);
            default:  pkt_s = 16'h0000;
        endcase
    end

    // Frame sequencer, SPI bit engine and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            load_ph_r      <= 1'b0;
            init_active_r  <= 1'b0;
            init_pending_r <= 1'b1;
            idx_r          <= 3'd0;
            row_r          <= '0;
            div_r          <= '0;
            bit_r          <= 4'd15;
            tail_r         <= 1'b0;
            shreg_r        <= 16'h0000;
            sck_r          <= 1'b0;
            mosi_r         <= 1'b0;
            cs_n_r         <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;

            if (state_r == ST_IDLE && bus.start) begin
                init_pending_r <= 1'b0;
            end else if (bus.init) begin
                init_pending_r <= 1'b1;
            end else begin
                init_pending_r <= init_pending_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_r    <= 1'b1;
                        row_r     <= '0;
                        idx_r     <= 3'd0;
                        load_ph_r <= 1'b0;
                        if (init_pending_r || bus.init) begin
                            init_active_r <= 1'b1;
                        end else begin
                            init_active_r <= 1'b0;
                            state_r       <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    load_ph_r <= ~load_ph_r;
                end
                ST_SHIFT: begin
                    div_r <= div_wrap_s ? '0 : div_r + DIV_W'(1);
                    if (div_wrap_s) begin
                        if (tail_r) begin
                            tail_r  <= 1'b0;
                            cs_n_r  <= 1'b1;
                            mosi_r  <= 1'b0;
                            state_r <= ST_GAP;
                        end else if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else begin
                            sck_r <= 1'b0;
                            if (bit_r == 4'd0) begin
                                tail_r <= 1'b1;
                            end else begin
                                bit_r   <= bit_r - 4'd1;
                                shreg_r <= {shreg_r[14:0], 1'b0};
                                mosi_r  <= shreg_r[14];
                            end
                        end
                    end
                end
                ST_GAP: begin
                    div_r <= div_wrap_s ? '0 : div_r + DIV_W'(1);
                    if (div_wrap_s) begin
                        if (init_active_r && idx_r != 3'd4) begin
                            idx_r <= idx_r + 3'd1;
                        end else if (init_active_r) begin
                            init_active_r <= 1'b0;
                            row_r         <= '0;
                            load_ph_r     <= 1'b0;
                            state_r       <= ST_LOAD;
                        end else if (row_r == ROW_LAST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            row_r     <= row_r + ROW_W'(1);
                            load_ph_r <= 1'b0;
                            state_r   <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_n_r  <= 1'b1;
                    sck_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase

            // Launch overrides the case above: CS falls with bit 15 already on MOSI.
            if (launch_s) begin
                shreg_r <= pkt_s;
                mosi_r  <= pkt_s[15];
                cs_n_r  <= 1'b0;
                sck_r   <= 1'b0;
                div_r   <= '0;
                bit_r   <= 4'd15;
                tail_r  <= 1'b0;
                state_r <= ST_SHIFT;
            end
        end
    end

    assign bus.row_select = row_r;
    assign bus.spi_sck    = sck_r;
    assign bus.spi_mosi   = mosi_r;
    assign bus.spi_cs_n   = cs_n_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = done_r;
endmodule

// File: tb/tb_silife_max7219_scan.sv
// Directed bench: decodes the SPI stream into packets and phase lengths and checks them
// against hand-derived packet lists and frame timings.
module tb_silife_max7219_scan;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    silife_max7219_scan_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    silife_max7219_scan #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] pk_q[$];
    int          nb_q[$];
    int          hi_q[$];
    int          lo_q[$];
    int          cs_q[$];
    int          gap_q[$];
    int          fd_cnt = 0;
    int          bf_cnt = 0;
    time         fd_t = 0;
    time         bf_t = 0;
    time         start_t = 0;

    int pk_b, hi_b, lo_b, cs_b, gap_b, fd_b, bf_b;

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] pat(input int r);
        logic [7:0] b;
        b = 8'h81;
        return b << r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Matrix model: cells follow row_select one cycle later.
    initial forever begin
        @(posedge clk);
        bus.cells <= pat(int'(bus.row_select));
    end

    // SPI decoder and phase-length recorder.
    initial begin
        logic        prev_sck, prev_cs, had_pkt;
        int          sck_run, cs_run, hi_run, nbits;
        logic [15:0] word;
        prev_sck = 1'b0; prev_cs = 1'b1; had_pkt = 1'b0;
        sck_run = 0; cs_run = 0; hi_run = 0; nbits = 0; word = 16'h0000;
        forever begin
            @(posedge clk);
            if (!reset) begin
                prev_sck = 1'b0; prev_cs = 1'b1; had_pkt = 1'b0;
                sck_run = 0; cs_run = 0; hi_run = 0; nbits = 0;
            end else begin
                if (bus.frame_done) had_pkt = 1'b0;
                if (!bus.spi_cs_n && prev_cs) begin
                    if (had_pkt) gap_q.push_back(hi_run);
                    cs_run = 1; sck_run = 1; word = 16'h0000; nbits = 0;
                end else if (!bus.spi_cs_n) begin
                    cs_run++;
                    if (bus.spi_sck == prev_sck) begin
                        sck_run++;
                    end else begin
                        if (prev_sck) hi_q.push_back(sck_run);
                        else lo_q.push_back(sck_run);
                        sck_run = 1;
                        if (bus.spi_sck) begin
                            word = {word[14:0], bus.spi_mosi};
                            nbits++;
                        end
                    end
                end else if (!prev_cs) begin
                    if (prev_sck) hi_q.push_back(sck_run);
                    else lo_q.push_back(sck_run);
                    cs_q.push_back(cs_run);
                    pk_q.push_back(word);
                    nb_q.push_back(nbits);
                    had_pkt = 1'b1;
                    hi_run = 1;
                end else begin
                    hi_run++;
                end
                prev_sck = bus.spi_sck;
                prev_cs  = bus.spi_cs_n;
            end
        end
    end

    initial forever begin
        @(posedge bus.frame_done);
        fd_t = $time;
        fd_cnt++;
    end

    initial forever begin
        @(negedge bus.busy);
        bf_t = $time;
        bf_cnt++;
    end

    task automatic snap();
        pk_b = pk_q.size(); hi_b = hi_q.size(); lo_b = lo_q.size();
        cs_b = cs_q.size(); gap_b = gap_q.size(); fd_b = fd_cnt; bf_b = bf_cnt;
    endtask

    task automatic pulse_start(input logic with_init);
        @(negedge clk);
        bus.start = 1'b1;
        bus.init  = with_init;
        @(posedge clk);
        start_t = $time;
        @(negedge clk);
        bus.start = 1'b0;
        bus.init  = 1'b0;
    endtask

    task automatic pulse_at(input int cycles, input logic s, input logic i);
        repeat (cycles) @(negedge clk);
        bus.start = s;
        bus.init  = i;
        @(negedge clk);
        bus.start = 1'b0;
        bus.init  = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        int n;
        n = 0;
        while (fd_cnt == fd_b && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 32'(fd_cnt != fd_b), 32'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input logic with_init, input logic [3:0] inten);
        logic [15:0] exp_q[$];
        int npk, hb, lb, cb, gb, g_exp;
        if (with_init) begin
            exp_q.push_back(16'h0F00);
            exp_q.push_back(16'h0900);
            exp_q.push_back({8'h0A, 4'h0, inten});
            exp_q.push_back(16'h0B07);
            exp_q.push_back(16'h0C01);
        end
        for (int r = 0; r < H; r++) exp_q.push_back({8'(r + 1), pat(r)});
        npk = pk_q.size() - pk_b;
        chk({nm, "_npkt"}, 32'(npk), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (pk_b + i < pk_q.size()) begin
                chk($sformatf("%s_pkt%0d", nm, i), 32'(pk_q[pk_b + i]), 32'(exp_q[i]));
                chk($sformatf("%s_bits%0d", nm, i), 32'(nb_q[pk_b + i]), 32'd16);
            end
        end
        chk({nm, "_cycles"}, 32'((fd_t - start_t) / 10),
            32'((with_init ? 5 * 34 * CD : 0) + H * (34 * CD + 2)));
        chk({nm, "_done_cnt"}, 32'(fd_cnt - fd_b), 32'd1);
        chk({nm, "_busy_falls"}, 32'(bf_cnt - bf_b), 32'd1);
        chk({nm, "_busy_fall_t"}, 32'((bf_t - fd_t) / 10), 32'd0);
        hb = 0; lb = 0; cb = 0; gb = 0;
        for (int i = hi_b; i < hi_q.size(); i++) if (hi_q[i] != CD) hb++;
        for (int i = lo_b; i < lo_q.size(); i++) if (lo_q[i] != CD) lb++;
        for (int i = cs_b; i < cs_q.size(); i++) if (cs_q[i] != 33 * CD) cb++;
        chk({nm, "_nhi"}, 32'(hi_q.size() - hi_b), 32'(16 * exp_q.size()));
        chk({nm, "_nlo"}, 32'(lo_q.size() - lo_b), 32'(17 * exp_q.size()));
        chk({nm, "_hi_len_bad"}, 32'(hb), 32'd0);
        chk({nm, "_lo_len_bad"}, 32'(lb), 32'd0);
        chk({nm, "_cs_len_bad"}, 32'(cb), 32'd0);
        chk({nm, "_ngap"}, 32'(gap_q.size() - gap_b), 32'(exp_q.size() - 1));
        for (int i = 0; i + gap_b < gap_q.size(); i++) begin
            g_exp = (with_init && i < 4) ? CD : CD + 2;
            if (gap_q[gap_b + i] != g_exp) gb++;
        end
        chk({nm, "_gap_bad"}, 32'(gb), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.init = 1'b0;
        bus.intensity = 4'h7;
        bus.cells = 8'h00;
        #2 reset = 1'b0;
        #20;
        chk("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        chk("rst_sck", 32'(bus.spi_sck), 32'd0);
        chk("rst_mosi", 32'(bus.spi_mosi), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_row", 32'(bus.row_select), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Init is pending out of reset.
        snap();
        pulse_start(1'b0);
        wait_frame("f1");
        check_frame("f1", 1'b1, 4'h7);

        // Plain frame with stray starts during SHIFT.
        snap();
        pulse_start(1'b0);
        pulse_at(50, 1'b1, 1'b0);
        pulse_at(30, 1'b1, 1'b0);
        wait_frame("f2");
        check_frame("f2", 1'b0, 4'h7);
        repeat (300) @(negedge clk);
        chk("f2_no_extra_pkts", 32'(pk_q.size() - pk_b), 32'(H));
        chk("f2_idle_busy", 32'(bus.busy), 32'd0);
        chk("f2_row_hold", 32'(bus.row_select), 32'(H - 1));

        // init while busy leaves this frame alone, applies to the next.
        snap();
        pulse_start(1'b0);
        pulse_at(60, 1'b0, 1'b1);
        wait_frame("f3");
        check_frame("f3", 1'b0, 4'h7);
        bus.intensity = 4'hA;
        snap();
        pulse_start(1'b0);
        wait_frame("f4");
        check_frame("f4", 1'b1, 4'hA);

        // init coinciding with start in IDLE.
        bus.intensity = 4'h3;
        snap();
        pulse_start(1'b1);
        wait_frame("f5");
        check_frame("f5", 1'b1, 4'h3);

        // Reset mid-SHIFT aborts at once and re-arms init.
        pulse_start(1'b0);
        repeat (20) @(negedge clk);
        chk("pre_rst_cs_low", 32'(bus.spi_cs_n), 32'd0);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        chk("mid_rst_sck", 32'(bus.spi_sck), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_row", 32'(bus.row_select), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.intensity = 4'h7;
        snap();
        pulse_start(1'b0);
        wait_frame("f6");
        check_frame("f6", 1'b1, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
